lsu_align_seq: RTL



---
 rtl/lsu_align_seq.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_align_seq.sv
// lsu_align_seq: sequential load/store alignment unit between execute and the
// data-memory port. One request at a time; word-crossing accesses may be split
// into two byte-enabled beats; load results are aligned and sign/zero extended.
module lsu_align_seq #(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_store_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              rsp_valid_o,
    output logic              rsp_err_o,
    output logic              reg_w_ena_o,
    output logic [4:0]        reg_w_addr_o,
    output logic [XLEN-1:0]   reg_w_data_o
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef logic [2*NB-1:0]   mask2_t;
    typedef logic [2*XLEN-1:0] data2_t;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_REQ1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    logic [2:0]        r_state;
    logic              r_store;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [4:0]        r_rd;
    logic              r_err;
    logic              r_cross;
    logic [XLEN-1:0]   r_rdata0;
    logic [XLEN-1:0]   r_rdata1;

    logic              w_legal;
    logic [4:0]        w_end;
    logic              w_cross;
    logic              w_err;
    mask2_t            w_size_mask;
    mask2_t            w_lane_mask;
    data2_t            w_lane_data;
    logic              w_beat1;
    logic [ADDR_W-1:0] w_beat_addr;
    logic [XLEN-1:0]   w_rd_shift;
    logic              w_sign;
    logic [XLEN-1:0]   w_ext;

    // Legality of the incoming funct3 for the request direction and XLEN.
    always_comb begin
        w_legal = 1'b0;
        case (req_funct3_i)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b011:                 w_legal = (XLEN == 64);
            3'b100, 3'b101:         w_legal = !req_store_i;
            3'b110:                 w_legal = !req_store_i && (XLEN == 64);
            default:                w_legal = 1'b0;
        endcase
    end

    assign w_end   = 5'(req_addr_i[OW-1:0]) + (5'd1 << req_funct3_i[1:0]);
    assign w_cross = (w_end > 5'(NB));
    assign w_err   = !w_legal || (w_cross && !SPLIT_MISALIGNED);

    // Unshifted byte mask for the captured access size.
    always_comb begin
        w_size_mask = '0;
        case (r_funct3[1:0])
            2'b00:   w_size_mask = mask2_t'(8'h01);
            2'b01:   w_size_mask = mask2_t'(8'h03);
            2'b10:   w_size_mask = mask2_t'(8'h0F);
            default: w_size_mask = mask2_t'(8'hFF);
        endcase
    end

    // Shifting into a double-width window yields beat0 in the low half and
    // beat1 (the spill past the lane boundary) in the high half.
    assign w_lane_mask = w_size_mask << r_addr[OW-1:0];
    assign w_lane_data = {{XLEN{1'b0}}, r_wdata} << {r_addr[OW-1:0], 3'b000};
    assign w_beat1     = (r_state == S_REQ1);
    assign w_beat_addr = {r_addr[ADDR_W-1:OW], {OW{1'b0}}}
                       + (w_beat1 ? ADDR_W'(NB) : ADDR_W'(0));

    assign req_ready_o = (r_state == S_IDLE);
    assign mem_req_o   = (r_state == S_REQ0) || (r_state == S_REQ1);
    assign mem_we_o    = mem_req_o && r_store;
    assign mem_addr_o  = mem_req_o ? w_beat_addr : '0;
    assign mem_be_o    = !mem_req_o ? '0 :
                         (w_beat1 ? w_lane_mask[2*NB-1:NB] : w_lane_mask[NB-1:0]);
    assign mem_wdata_o = !mem_req_o ? '0 :
                         (w_beat1 ? w_lane_data[2*XLEN-1:XLEN] : w_lane_data[XLEN-1:0]);

    assign w_rd_shift = XLEN'({r_rdata1, r_rdata0} >> {r_addr[OW-1:0], 3'b000});

    // Sign bit of the loaded value at the access size.
    always_comb begin
        w_sign = 1'b0;
        case (r_funct3[1:0])
            2'b00:   w_sign = w_rd_shift[7];
            2'b01:   w_sign = w_rd_shift[15];
            2'b10:   w_sign = w_rd_shift[31];
            default: w_sign = w_rd_shift[XLEN-1];
        endcase
    end

    // Keep the access-size bytes and fill the rest with sign or zero.
    always_comb begin
        w_ext = '0;
        for (int unsigned i = 0; i < XLEN; i++) begin
            if (i < (32'd8 << r_funct3[1:0])) begin
                w_ext[i] = w_rd_shift[i];
            end else begin
                w_ext[i] = w_sign && !r_funct3[2];
            end
        end
    end

    assign rsp_valid_o  = (r_state == S_RESP);
    assign rsp_err_o    = rsp_valid_o && r_err;
    assign reg_w_ena_o  = rsp_valid_o && !r_store && !r_err && (r_rd != 5'd0);
    assign reg_w_addr_o = reg_w_ena_o ? r_rd : '0;
    assign reg_w_data_o = reg_w_ena_o ? w_ext : '0;

    // Sequencer: capture at accept, issue beats, collect responses, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_store  <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rd     <= '0;
            r_err    <= 1'b0;
            r_cross  <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_store  <= req_store_i;
                        r_funct3 <= req_funct3_i;
                        r_addr   <= req_addr_i;
                        r_wdata  <= req_wdata_i;
                        r_rd     <= req_rd_i;
                        r_err    <= w_err;
                        r_cross  <= w_cross;
                        r_state  <= w_err ? S_RESP : S_REQ0;
                    end
                end
                S_REQ0: begin
                    if (mem_gnt_i) r_state <= S_WAIT0;
                end
                S_WAIT0: begin
                    if (mem_rvalid_i) begin
                        r_rdata0 <= mem_rdata_i;
                        r_state  <= r_cross ? S_REQ1 : S_RESP;
                    end
                end
                S_REQ1: begin
                    if (mem_gnt_i) r_state <= S_WAIT1;
                end
                S_WAIT1: begin
                    if (mem_rvalid_i) begin
                        r_rdata1 <= mem_rdata_i;
                        r_state  <= S_RESP;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
